// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

  // Width of the wait-state counter; covers LATENCY up to 15.
  localparam int CNT_W = 4;

  // Word index of a byte address.
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: asynchronous read, per-byte-lane synchronous write.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Lane-masked write; the caller only enables lanes for in-range indices.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: stalls for LATENCY cycles per
// access, returns load data / fault in the completion cycle.
// Optional macro DMEM_BYTE_EN enables byte (LDRB/STRB) accesses via ByteM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        MemErrM
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  logic        req;
  logic        byte_eff;
  logic [29:0] live_widx;
  logic        live_err;

  assign req = MemReadM | MemWriteM;

`ifdef DMEM_BYTE_EN
  assign byte_eff = ByteM;
`else
  logic unused_byte;
  assign unused_byte = ByteM;
  assign byte_eff    = 1'b0;
`endif

  assign live_widx = word_index(ALUOutM);
  assign live_err  = (live_widx >= 30'(DEPTH_WORDS))
                   | (!byte_eff && (ALUOutM[1:0] != 2'b00))
                   | (MemReadM & MemWriteM);

  dmem_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]  l_idx;
  logic [1:0]     l_lane;
  logic [31:0]    l_data;
  logic           l_write, l_byte, l_err;

  // Request latch and wait-state sequencing; inputs are ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      l_idx   <= '0;
      l_lane  <= '0;
      l_data  <= '0;
      l_write <= 1'b0;
      l_byte  <= 1'b0;
      l_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && LATENCY > 0) begin
          l_idx   <= live_widx[AW-1:0];
          l_lane  <= ALUOutM[1:0];
          l_data  <= WriteDataM;
          l_write <= MemWriteM;
          l_byte  <= byte_eff;
          l_err   <= live_err;
          cnt     <= CNT_INIT;
          state   <= (LATENCY > 1) ? WAIT : DONE;
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion view: live inputs when there are no wait states, latched copy otherwise.
  logic          cur_done, cur_write, cur_byte, cur_err;
  logic [AW-1:0] cur_idx;
  logic [1:0]    cur_lane;
  logic [31:0]   cur_data;

  always_comb begin
    if (LATENCY == 0) begin
      cur_done  = req;
      cur_write = MemWriteM;
      cur_byte  = byte_eff;
      cur_err   = live_err;
      cur_idx   = live_widx[AW-1:0];
      cur_lane  = ALUOutM[1:0];
      cur_data  = WriteDataM;
    end else begin
      cur_done  = (state == DONE);
      cur_write = l_write;
      cur_byte  = l_byte;
      cur_err   = l_err;
      cur_idx   = l_idx;
      cur_lane  = l_lane;
      cur_data  = l_data;
    end
  end

  logic [3:0]  we;
  logic [31:0] wdata, rword;

  // Commit only good writes; a reset in the completion cycle drops the write.
  always_comb begin
    we    = 4'h0;
    wdata = cur_byte ? {4{cur_data[7:0]}} : cur_data;
    if (!reset && cur_done && cur_write && !cur_err)
      we = cur_byte ? (4'b0001 << cur_lane) : 4'hF;
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (cur_idx),
    .wdata (wdata),
    .rdata (rword)
  );

  // Outputs are zero outside the completion cycle and while reset is held.
  always_comb begin
    ReadDataM = '0;
    MemErrM   = 1'b0;
    MemStallM = 1'b0;
    if (!reset) begin
      MemStallM = (LATENCY > 0) && (((state == IDLE) && req) || (state == WAIT));
      MemErrM   = cur_done && cur_err;
      if (cur_done && !cur_write && !cur_err)
        ReadDataM = cur_byte ? {24'b0, rword[{cur_lane, 3'b000} +: 8]} : rword;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 0, 3), each
// checked every cycle against a transaction-level model, plus literal checks.
module tb_dmem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mr [N], mw [N], bm [N];
  logic [31:0] ad [N], wd [N], rdat [N];
  logic        stl [N], er [N];
  int          tests = 0;
  int          fails = 0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, g, $time, got, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : lane
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 0 : 3;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (mr[g]),
      .MemWriteM  (mw[g]),
      .ByteM      (bm[g]),
      .ALUOutM    (ad[g]),
      .WriteDataM (wd[g]),
      .ReadDataM  (rdat[g]),
      .MemStallM  (stl[g]),
      .MemErrM    (er[g])
    );

    logic [31:0] m [64];
    bit          known [64];
    int          rem = -1;
    logic        p_rd, p_wr, p_bt;
    logic [31:0] p_a, p_d;

    // Resolve one access against the reference memory (read before write).
    function automatic void complete(input logic rd, input logic wr, input logic bt,
                                     input logic [31:0] a, input logic [31:0] d,
                                     output logic err, output logic [31:0] val, output logic ck);
      int   idx, ln;
      logic beff;
`ifdef DMEM_BYTE_EN
      beff = bt;
`else
      beff = bt & 1'b0;
`endif
      idx = int'(a >> 2);
      ln  = int'(a[1:0]);
      err = (idx >= 64) || (!beff && a[1:0] != 2'b00) || (rd && wr);
      val = '0;
      ck  = 1'b1;
      if (rd && !err) begin
        ck  = known[idx];
        val = beff ? ((m[idx] >> (8 * ln)) & 32'hFF) : m[idx];
      end
      if (wr && !err) begin
        if (beff) m[idx][8*ln +: 8] = d[7:0];
        else begin
          m[idx]     = d;
          known[idx] = 1'b1;
        end
      end
    endfunction

    // Busy-for-LAT-cycles model: accept, stall LAT cycles, complete.
    always @(negedge clk) begin
      logic        e_st, e_er, ck, fin;
      logic [31:0] e_rd;
      logic        c_rd, c_wr, c_bt;
      logic [31:0] c_a, c_d;
      if (reset) rem = -1;
      else if (started) begin
        e_st = 1'b0; e_er = 1'b0; e_rd = '0; ck = 1'b1; fin = 1'b0;
        c_rd = 1'b0; c_wr = 1'b0; c_bt = 1'b0; c_a = '0; c_d = '0;
        if (rem < 0) begin
          if (mr[g] || mw[g]) begin
            if (LAT == 0) begin
              fin = 1'b1;
              c_rd = mr[g]; c_wr = mw[g]; c_bt = bm[g]; c_a = ad[g]; c_d = wd[g];
            end else begin
              e_st = 1'b1;
              p_rd = mr[g]; p_wr = mw[g]; p_bt = bm[g]; p_a = ad[g]; p_d = wd[g];
              rem  = LAT - 1;
            end
          end
        end else if (rem > 0) begin
          e_st = 1'b1;
          rem--;
        end else begin
          fin = 1'b1;
          c_rd = p_rd; c_wr = p_wr; c_bt = p_bt; c_a = p_a; c_d = p_d;
          rem = -1;
        end
        if (fin) complete(c_rd, c_wr, c_bt, c_a, c_d, e_er, e_rd, ck);
        cmp("stall", g, 32'(stl[g]), 32'(e_st));
        cmp("err", g, 32'(er[g]), 32'(e_er));
        if (ck) cmp("rdata", g, rdat[g], e_rd);
      end
    end
  end

  // Drive one access starting at posedge+1; addr switches to alt after the accept cycle.
  task automatic access(input int i, input logic rd, input logic wr, input logic bt,
                        input logic [31:0] a, input logic [31:0] alt, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err, output int stalls);
    mr[i] = rd; mw[i] = wr; bm[i] = bt; ad[i] = a; wd[i] = d;
    stalls = 0;
    #1;
    while (stl[i] && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      if (stalls == 1) begin
        ad[i] = alt;
        #1;
      end
    end
    if (stalls >= 40) cmp("timeout", i, 32'(stalls), 32'd0);
    rdata = rdat[i];
    err   = er[i];
    @(posedge clk); #1;
    mr[i] = 1'b0; mw[i] = 1'b0; bm[i] = 1'b0; ad[i] = '0; wd[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          s;
    for (int i = 0; i < N; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; bm[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    started = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      cmp("rst_stall", i, 32'(stl[i]), 32'd0);
      cmp("rst_rdata", i, rdat[i], 32'd0);
      cmp("rst_err", i, 32'(er[i]), 32'd0);
    end

    // LATENCY=2: store then load
    access(0, 0, 1, 0, 32'h10, 32'h10, 32'hDEADBEEF, r, e, s);
    cmp("l2_st_stalls", 0, 32'(s), 32'd2);
    cmp("l2_st_err", 0, 32'(e), 32'd0);
    access(0, 1, 0, 0, 32'h10, 32'h10, 32'h0, r, e, s);
    cmp("l2_ld_stalls", 0, 32'(s), 32'd2);
    cmp("l2_ld_data", 0, r, 32'hDEADBEEF);
    cmp("l2_ld_err", 0, 32'(e), 32'd0);

    // Faults: misaligned, out of range, read+write together
    access(0, 0, 1, 0, 32'h12, 32'h12, 32'hCAFEF00D, r, e, s);
    cmp("mis_st_err", 0, 32'(e), 32'd1);
    cmp("mis_st_stalls", 0, 32'(s), 32'd2);
    access(0, 1, 0, 0, 32'h102, 32'h102, 32'h0, r, e, s);
    cmp("mis_ld_err", 0, 32'(e), 32'd1);
    cmp("mis_ld_data", 0, r, 32'd0);
    access(0, 1, 0, 0, 32'h100, 32'h100, 32'h0, r, e, s);
    cmp("oor_ld_err", 0, 32'(e), 32'd1);
    cmp("oor_ld_data", 0, r, 32'd0);
    access(0, 0, 1, 0, 32'h100, 32'h100, 32'h5A5A5A5A, r, e, s);
    cmp("oor_st_err", 0, 32'(e), 32'd1);
    access(0, 1, 1, 0, 32'h10, 32'h10, 32'h77777777, r, e, s);
    cmp("rw_err", 0, 32'(e), 32'd1);
    access(0, 1, 0, 0, 32'h10, 32'h10, 32'h0, r, e, s);
    cmp("after_err_data", 0, r, 32'hDEADBEEF);

`ifdef DMEM_BYTE_EN
    access(0, 0, 1, 0, 32'h4, 32'h4, 32'h11223344, r, e, s);
    access(0, 0, 1, 1, 32'h5, 32'h5, 32'h000000FF, r, e, s);
    cmp("strb_err", 0, 32'(e), 32'd0);
    access(0, 1, 0, 0, 32'h4, 32'h4, 32'h0, r, e, s);
    cmp("strb_word", 0, r, 32'h1122FF44);
    access(0, 1, 0, 1, 32'h6, 32'h6, 32'h0, r, e, s);
    cmp("ldrb_data", 0, r, 32'h00000022);
`else
    access(0, 0, 1, 0, 32'h4, 32'h4, 32'h11223344, r, e, s);
    access(0, 0, 1, 1, 32'h5, 32'h5, 32'h000000FF, r, e, s);
    cmp("byte_ign_err", 0, 32'(e), 32'd1);
    access(0, 1, 0, 1, 32'h4, 32'h4, 32'h0, r, e, s);
    cmp("byte_ign_word", 0, r, 32'h11223344);
`endif

    // LATENCY=0: back-to-back store/load, no stall, same-cycle data
    access(1, 0, 1, 0, 32'h0, 32'h0, 32'h12345678, r, e, s);
    cmp("l0_st_stalls", 1, 32'(s), 32'd0);
    access(1, 1, 0, 0, 32'h0, 32'h0, 32'h0, r, e, s);
    cmp("l0_ld_stalls", 1, 32'(s), 32'd0);
    cmp("l0_ld_data", 1, r, 32'h12345678);

    // LATENCY=3: address changes during WAIT are ignored
    access(2, 0, 1, 0, 32'h20, 32'h20, 32'h0BADCAFE, r, e, s);
    access(2, 0, 1, 0, 32'h10, 32'h10, 32'h600DF00D, r, e, s);
    access(2, 1, 0, 0, 32'h10, 32'h20, 32'h0, r, e, s);
    cmp("l3_ld_stalls", 2, 32'(s), 32'd3);
    cmp("l3_ld_data", 2, r, 32'h600DF00D);

    // Reset during WAIT discards the pending store
    access(2, 0, 1, 0, 32'h8, 32'h8, 32'h55555555, r, e, s);
    mw[2] = 1'b1; ad[2] = 32'h8; wd[2] = 32'hAAAAAAAA;
    #1 cmp("rst_acc_stall", 2, 32'(stl[2]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    mw[2] = 1'b0; ad[2] = '0; wd[2] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1 cmp("rst_after_stall", 2, 32'(stl[2]), 32'd0);
    access(2, 1, 0, 0, 32'h8, 32'h8, 32'h0, r, e, s);
    cmp("rst_ld_data", 2, r, 32'h55555555);
    cmp("rst_ld_err", 2, 32'(e), 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
